// File: rtl/srt_r4_multiple_pipe.sv
// Radix-4 SRT multiple generator and partial-remainder updater.
// Holds precomputed divisor multiples and, per digit, returns q*D or 4*w - q*D.
module srt_r4_multiple_pipe #(
    parameter int W      = 8,
    parameter int REM_W  = W + 3,
    parameter int PROD_W = 2 * W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_load,
    input  logic [W-1:0]      divisor_in,
    output logic              div_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        q_digit,
    input  logic [REM_W-1:0]  rem_in,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic [REM_W-1:0]  rem_out,
    output logic              illegal,
    output logic              ovf
);
    // Multiples carry two extra bits so that -2*(-2^(W-1)) stays exact.
    localparam int MW = W + 2;
    localparam int EW = REM_W + 3;

    logic [MW-1:0]     d1_r, d2_r, dn1_r, dn2_r;
    logic              s1_valid_r, s2_valid_r;
    logic [REM_W-1:0]  s1_rem_r;
    logic              s1_mode_r;
    logic [4:0]        s1_sel_r;
    logic              s1_ill_r;
    logic [PROD_W-1:0] product_r;
    logic [REM_W-1:0]  rem_r;
    logic              ill_r, ovf_r, div_err_r;

    logic              busy_s, load_acc_s, s1_adv_s, s2_adv_s, accept_s;
    logic [4:0]        sel_s;
    logic              ill_s;
    logic [MW-1:0]     mult_s;
    logic [MW-1:0]     d_ext_s;
    logic [EW-1:0]     exact_s;
    logic              ovf_s;
    logic [PROD_W-1:0] prod_s;

    assign busy_s     = s1_valid_r | s2_valid_r;
    assign load_acc_s = div_load & ~busy_s;
    assign s2_adv_s   = ~s2_valid_r | out_ready;
    assign s1_adv_s   = ~s1_valid_r | s2_adv_s;
    assign in_ready   = s1_adv_s & ~load_acc_s;
    assign accept_s   = in_valid & in_ready;
    assign d_ext_s    = {{2{divisor_in[W-1]}}, divisor_in};

    // Decode the quotient digit to a one-hot multiple select {+2,+1,0,-1,-2}.
    always_comb begin
        sel_s = 5'b00000;
        ill_s = 1'b0;
        case (q_digit)
            3'b110:  sel_s = 5'b00001;
            3'b111:  sel_s = 5'b00010;
            3'b000:  sel_s = 5'b00100;
            3'b001:  sel_s = 5'b01000;
            3'b010:  sel_s = 5'b10000;
            default: ill_s = 1'b1;
        endcase
    end

    // Select the precomputed multiple q*D for the digit held in stage 1.
    always_comb begin
        mult_s = {MW{1'b0}};
        case (s1_sel_r)
            5'b00001: mult_s = dn2_r;
            5'b00010: mult_s = dn1_r;
            5'b00100: mult_s = {MW{1'b0}};
            5'b01000: mult_s = d1_r;
            5'b10000: mult_s = d2_r;
            default:  mult_s = {MW{1'b0}};
        endcase
    end

    // Exact 4*w - q*D, wide enough that the overflow test sees the true sign.
    always_comb begin
        exact_s = ({{(EW-REM_W){s1_rem_r[REM_W-1]}}, s1_rem_r} << 2)
                - {{(EW-MW){mult_s[MW-1]}}, mult_s};
        prod_s  = {{(PROD_W-MW){mult_s[MW-1]}}, mult_s};
        if ((exact_s[EW-1:REM_W-1] == {(EW-REM_W+1){1'b0}}) ||
            (exact_s[EW-1:REM_W-1] == {(EW-REM_W+1){1'b1}})) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = 1'b1;
        end
    end

    // Divisor multiples, rebuilt only when the pipeline is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r      <= {MW{1'b0}};
            d2_r      <= {MW{1'b0}};
            dn1_r     <= {MW{1'b0}};
            dn2_r     <= {MW{1'b0}};
            div_err_r <= 1'b0;
        end else begin
            div_err_r <= div_load & busy_s;
            if (load_acc_s) begin
                d1_r  <= d_ext_s;
                d2_r  <= d_ext_s << 1;
                dn1_r <= {MW{1'b0}} - d_ext_s;
                dn2_r <= {MW{1'b0}} - (d_ext_s << 1);
            end
        end
    end

    // Stage 1: capture the request and its decoded digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_rem_r   <= {REM_W{1'b0}};
            s1_mode_r  <= 1'b0;
            s1_sel_r   <= 5'b00000;
            s1_ill_r   <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_rem_r  <= rem_in;
                s1_mode_r <= mode;
                s1_sel_r  <= sel_s;
                s1_ill_r  <= ill_s;
            end
        end
    end

    // Stage 2: registered results; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            product_r  <= {PROD_W{1'b0}};
            rem_r      <= {REM_W{1'b0}};
            ill_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                if (s1_ill_r) begin
                    product_r <= {PROD_W{1'b0}};
                    rem_r     <= {REM_W{1'b0}};
                    ill_r     <= 1'b1;
                    ovf_r     <= 1'b0;
                end else begin
                    product_r <= prod_s;
                    rem_r     <= s1_mode_r ? exact_s[REM_W-1:0] : {REM_W{1'b0}};
                    ill_r     <= 1'b0;
                    ovf_r     <= s1_mode_r & ovf_s;
                end
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign product   = product_r;
    assign rem_out   = rem_r;
    assign illegal   = ill_r;
    assign ovf       = ovf_r;
    assign div_err   = div_err_r;

endmodule

// File: tb/tb_srt_r4_multiple_pipe.sv
// Randomised and directed bench for srt_r4_multiple_pipe with an arithmetic
// reference model and an in-order scoreboard.
module tb_srt_r4_multiple_pipe;
    localparam int W      = 8;
    localparam int REM_W  = 11;
    localparam int PROD_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              div_load = 1'b0;
    logic [W-1:0]      divisor_in = '0;
    logic              div_err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        q_digit = '0;
    logic [REM_W-1:0]  rem_in = '0;
    logic              mode = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [PROD_W-1:0] product;
    logic [REM_W-1:0]  rem_out;
    logic              illegal;
    logic              ovf;

    srt_r4_multiple_pipe #(.W(W), .REM_W(REM_W), .PROD_W(PROD_W)) dut (
        .clk(clk), .rst_n(rst_n), .div_load(div_load), .divisor_in(divisor_in),
        .div_err(div_err), .in_valid(in_valid), .in_ready(in_ready),
        .q_digit(q_digit), .rem_in(rem_in), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .rem_out(rem_out),
        .illegal(illegal), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] q; logic [REM_W-1:0] w; logic mode; } stim_t;
    typedef struct { logic [PROD_W-1:0] prod; logic [REM_W-1:0] rem; logic ill; logic ovf; int t; } exp_t;

    stim_t pend[$];
    exp_t  expq[$];
    int    n_chk = 0, n_bad = 0, cyc = 0, inflight = 0, d_m = 0;
    bit    exp_err = 1'b0, stall_prev = 1'b0, rand_rdy = 1'b0, check_lat = 1'b0;
    logic [PROD_W+REM_W+1:0] prev_bits = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain signed arithmetic from the digit rules.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        int qi, wi, p, x;
        qi = $signed(s.q);
        wi = $signed(s.w);
        e.t = cyc; e.prod = '0; e.rem = '0; e.ill = 1'b0; e.ovf = 1'b0;
        if (qi < -2 || qi > 2) begin
            e.ill = 1'b1;
        end else begin
            p = qi * d_m;
            e.prod = p[PROD_W-1:0];
            if (s.mode) begin
                x = 4 * wi - p;
                e.rem = x[REM_W-1:0];
                e.ovf = (x < -(1 << (REM_W-1))) || (x > (1 << (REM_W-1)) - 1);
            end
        end
        return e;
    endfunction

    task automatic push(input int q, input int w, input logic m);
        stim_t s;
        s.q = q[2:0]; s.w = w[REM_W-1:0]; s.mode = m;
        pend.push_back(s);
    endtask

    task automatic drive();
        in_valid = (pend.size() > 0);
        if (in_valid) begin
            q_digit = pend[0].q; rem_in = pend[0].w; mode = pend[0].mode;
        end
    endtask

    task automatic cycle();
        exp_t e;
        drive();
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        chk("div_err", div_err, exp_err);
        exp_err = 1'b0;
        if (stall_prev) chk("hold", {product, rem_out, illegal, ovf}, prev_bits);
        stall_prev = out_valid && !out_ready;
        prev_bits  = {product, rem_out, illegal, ovf};
        if (div_load) begin
            if (inflight == 0) begin
                d_m = $signed(divisor_in);
                chk("rdy_load", in_ready, 0);
            end else begin
                exp_err = 1'b1;
            end
        end
        if (out_valid && out_ready) begin
            inflight--;
            if (expq.size() == 0) begin
                chk("spurious", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("product", product, e.prod);
                chk("rem_out", rem_out, e.rem);
                chk("illegal", illegal, e.ill);
                chk("ovf", ovf, e.ovf);
                if (check_lat) chk("latency", cyc - e.t, 2);
            end
        end
        if (in_valid && in_ready) begin
            expq.push_back(model(pend[0]));
            void'(pend.pop_front());
            inflight++;
        end
        cyc++;
        @(posedge clk);
        #1;
        div_load = 1'b0;
        drive();
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (expq.size() > 0 || pend.size() > 0); i++) cycle();
        chk("drain", expq.size() + pend.size(), 0);
    endtask

    task automatic load(input int d);
        div_load = 1'b1;
        divisor_in = d[W-1:0];
        cycle();
    endtask

    initial begin
        #12;
        chk("rst_ovalid", out_valid, 0);
        chk("rst_derr", div_err, 0);
        chk("rst_prod", product, 0);
        chk("rst_rem", rem_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        // T1: products for every legal digit, back to back
        load(7);
        check_lat = 1'b1;
        push(-2, 0, 0); push(-1, 0, 0); push(0, 0, 0); push(1, 0, 0); push(2, 0, 0);
        drain();
        check_lat = 1'b0;

        // T2 / T3: remainder updates, including an overflowing one
        push(1, 5, 1); push(-2, 5, 1);
        drain();
        load(127);
        push(-2, 300, 1); push(2, -300, 1); push(-1, 1023, 1);
        drain();
        load(-128);
        push(-2, 0, 0); push(-2, -1024, 1); push(2, 1023, 1);
        drain();

        // T4: illegal digits, then a legal one
        load(7);
        push(3, 100, 1); push(-4, 5, 0); push(-3, 7, 1); push(1, 5, 1);
        drain();

        // T5: backpressure fills both stages
        out_ready = 1'b0;
        push(1, 1, 1); push(2, 2, 1); push(-1, 3, 1);
        repeat (4) cycle();
        chk("t5_ready", in_ready, 0);
        chk("t5_accepted", expq.size(), 2);
        drain();

        // T6: rejected load while busy, then reset mid-stream
        push(1, 0, 0);
        cycle();
        load(50);
        drain();
        push(2, 9, 1); push(-1, 4, 1); push(1, 2, 0);
        cycle(); cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_ovalid", out_valid, 0);
        chk("midrst_prod", product, 0);
        pend.delete(); expq.delete();
        inflight = 0; d_m = 0; stall_prev = 1'b0; exp_err = 1'b0;
        drive();
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(1, 0, 0); push(2, 5, 1);
        drain();

        // Random traffic with random backpressure and occasional loads
        load($urandom_range(0, 255));
        rand_rdy = 1'b1;
        repeat (400) begin
            if (pend.size() == 0 && $urandom_range(0, 3) != 0)
                push($urandom_range(0, 7), $urandom_range(0, 2047), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 15) == 0) begin
                div_load = 1'b1;
                divisor_in = 8'($urandom_range(0, 255));
            end
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
